wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Sits directly downstream of the execution top level and merges its two writeback streams into one physical-register write port and one ROB completion port.
- Streams: integer writeback (intwb_*) and memory writeback (memwb_*).
- Integer results have fixed priority. Colliding memory results are buffered in a small FIFO.
- Flush kills buffered and in-flight results younger than the redirecting instruction.

Parameters:
- PREG_W, 6, physical register index width
- ROBID_W, 7, ROB id width; MSB is the wrap bit, the low ROBID_W-1 bits are the index
- DATA_W, 64, result width
- DEPTH, 4, memory-result FIFO entries; power of two, minimum 2

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- int_valid  in  1  integer writeback valid; no backpressure, always accepted
- int_need_to_wb  in  1  integer result writes the register file
- int_prd  in  PREG_W  integer destination preg
- int_result  in  DATA_W  integer result
- int_robid  in  ROBID_W  integer ROB id
- mem_valid  in  1  memory writeback valid
- mem_need_to_wb  in  1  memory result writes the register file
- mem_prd  in  PREG_W  memory destination preg
- mem_result  in  DATA_W  load data
- mem_robid  in  ROBID_W  memory ROB id
- mem_mmio  in  1  access was MMIO
- flush_valid  in  1  redirect this cycle
- flush_robid  in  ROBID_W  ROB id of redirecting instruction
- rf_we  out  1  register-file write enable
- rf_waddr  out  PREG_W  write preg
- rf_wdata  out  DATA_W  write data
- cmt_valid  out  1  ROB completion valid
- cmt_robid  out  ROBID_W  completing ROB id
- cmt_mmio  out  1  completion is MMIO
- mem_stall  out  1  request to memory issue to hold new accesses
- ovf_err  out  1  sticky FIFO overflow flag

Behaviour:
- Reset: all outputs 0, FIFO empty (count 0, pointers 0), perf counters 0.
- Age rule: younger(a,f) = (a[MSB]==f[MSB]) ? a.idx > f.idx : a.idx < f.idx.
- Equal robid is never younger. The redirecting instruction itself always completes.
- Output stage is a register. Each cycle exactly one candidate is selected; it appears on the outputs the next cycle (latency 1).
- Selection priority:
  - int_valid wins.
  - Otherwise the FIFO head, if its entry is valid.
  - Otherwise mem_valid bypass, only when the FIFO is empty.
  - Otherwise the outputs go idle (cmt_valid=0, rf_we=0).
- Registered output fields: cmt_valid=1; rf_we=need_to_wb of the selected candidate; addr, data, robid and mmio from the candidate. Integer candidates set mmio=0.
- Memory push: mem_valid is pushed into the FIFO when it is not bypassed (int_valid high, or FIFO non-empty). Push order is preserved.
- Push when full (count==DEPTH and no pop this cycle): the entry is dropped and ovf_err sets; ovf_err clears only on reset. Simultaneous pop and push when full is legal.
- Killed FIFO entries: on flush_valid, every FIFO entry with younger(robid, flush_robid) has its valid bit cleared in the same cycle.
  - An invalid head is popped silently (one per cycle).
  - A silent pop produces no output. The next valid candidate (int, or mem bypass if the FIFO becomes empty) is still selected.
- Kills on a flush cycle: incoming int/mem candidates that are younger are neither selected nor pushed. A younger entry in the output register is suppressed the next cycle (cmt_valid=0, rf_we=0).
- mem_stall = registered (count_next >= DEPTH-1). It deasserts the cycle after count drops below DEPTH-1.
- Wrap-around: read/write pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Reset mid-operation: reset asserts asynchronously. The FIFO is emptied immediately and no write occurs while reset is high.

Optional Feature:
- Macro WB_ARB_PERF_EN.
- Defined: adds outputs perf_conflict_cnt (32) and perf_kill_cnt (32).
  - perf_conflict_cnt increments on each cycle where int_valid and mem_valid are both high.
  - perf_kill_cnt increments by the number of entries/candidates killed by flush in that cycle (saturating at all-ones).
- Undefined: both ports still exist and are tied to 0, so no counter logic is built.

Test Plan:
- int_valid only, prd=5, result=0x1234, robid=3 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, cmt_robid=3, cmt_mmio=0.
- Same cycle int robid=4 and mem robid=6 result=0xAB -> cycle+1 int robid=4 out; cycle+2 robid=6, rf_wdata=0xAB; FIFO count 1 then 0.
- 4 consecutive int+mem pairs with DEPTH=4 -> mem_stall=1 once count>=3. A 5th mem push at full with no pop -> ovf_err=1 and stays 1.
- FIFO holds robids 10,11,12; flush_robid=10 -> 11 and 12 killed and popped silently with no output; robid 10 completes. Wrap case: flush_robid=0x7E, entry 0x01 (wrap bit differs) is killed.
- mem_need_to_wb=0, mmio=1, FIFO empty, no int -> bypass, next cycle cmt_valid=1, rf_we=0, cmt_mmio=1.
- Assert reset while FIFO has 2 entries -> outputs 0 immediately, count 0; after release, first new mem_valid bypasses with latency 1.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: both writeback streams, the flush redirect, and the
// merged register-file / ROB completion side.
interface wb_arbiter_if #(
  parameter int PREG_W  = 6,
  parameter int ROBID_W = 7,
  parameter int DATA_W  = 64
);
  logic               int_valid;
  logic               int_need_to_wb;
  logic [PREG_W-1:0]  int_prd;
  logic [DATA_W-1:0]  int_result;
  logic [ROBID_W-1:0] int_robid;

  logic               mem_valid;
  logic               mem_need_to_wb;
  logic [PREG_W-1:0]  mem_prd;
  logic [DATA_W-1:0]  mem_result;
  logic [ROBID_W-1:0] mem_robid;
  logic               mem_mmio;

  logic               flush_valid;
  logic [ROBID_W-1:0] flush_robid;

  logic               rf_we;
  logic [PREG_W-1:0]  rf_waddr;
  logic [DATA_W-1:0]  rf_wdata;
  logic               cmt_valid;
  logic [ROBID_W-1:0] cmt_robid;
  logic               cmt_mmio;
  logic               mem_stall;
  logic               ovf_err;
  logic [31:0]        perf_conflict_cnt;
  logic [31:0]        perf_kill_cnt;

  // Arbiter side
  modport slave (
    input  int_valid, int_need_to_wb, int_prd, int_result, int_robid,
    input  mem_valid, mem_need_to_wb, mem_prd, mem_result, mem_robid, mem_mmio,
    input  flush_valid, flush_robid,
    output rf_we, rf_waddr, rf_wdata, cmt_valid, cmt_robid, cmt_mmio,
    output mem_stall, ovf_err, perf_conflict_cnt, perf_kill_cnt
  );

  // Execution / commit side
  modport master (
    output int_valid, int_need_to_wb, int_prd, int_result, int_robid,
    output mem_valid, mem_need_to_wb, mem_prd, mem_result, mem_robid, mem_mmio,
    output flush_valid, flush_robid,
    input  rf_we, rf_waddr, rf_wdata, cmt_valid, cmt_robid, cmt_mmio,
    input  mem_stall, ovf_err, perf_conflict_cnt, perf_kill_cnt
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges integer and memory writeback into one register
// write port and one ROB completion port. Integer results win; colliding
// memory results wait in a small FIFO. A flush kills anything younger than
// the redirecting instruction. Define WB_ARB_PERF_EN to build the
// conflict/kill performance counters; otherwise they read as zero.
module wb_arbiter #(
  parameter int PREG_W  = 6,
  parameter int ROBID_W = 7,
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 4
) (
  input logic         clock,
  input logic         reset,
  wb_arbiter_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int IDX_W = ROBID_W - 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] STALL_CNT = CW'(DEPTH - 1);

  // Wrap bit equal: larger index is younger; wrap bit differs: smaller index is younger.
  function automatic logic younger(input logic [ROBID_W-1:0] a, input logic [ROBID_W-1:0] f);
    if (a[ROBID_W-1] == f[ROBID_W-1]) return a[IDX_W-1:0] > f[IDX_W-1:0];
    else                              return a[IDX_W-1:0] < f[IDX_W-1:0];
  endfunction

  logic [DEPTH-1:0]   ent_valid;
  logic               ent_need  [DEPTH];
  logic [PREG_W-1:0]  ent_prd   [DEPTH];
  logic [DATA_W-1:0]  ent_data  [DEPTH];
  logic [ROBID_W-1:0] ent_robid [DEPTH];
  logic               ent_mmio  [DEPTH];
  logic [AW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      count, count_next;

  logic [DEPTH-1:0]   kill_vec;
  logic               int_killed, mem_killed, int_ok, mem_ok;
  logic               head_live, silent_pop, fifo_drained, bypass;
  logic               pop, push_req, push, overflow;
  logic               sel_any, sel_need, sel_mmio;
  logic [PREG_W-1:0]  sel_prd;
  logic [DATA_W-1:0]  sel_data;
  logic [ROBID_W-1:0] sel_robid;

  // Kill detection, candidate selection and FIFO push/pop decisions for this cycle
  always_comb begin
    kill_vec = '0;
    for (int i = 0; i < DEPTH; i++)
      kill_vec[i] = bus.flush_valid && ent_valid[i] && younger(ent_robid[i], bus.flush_robid);
    int_killed   = bus.int_valid && bus.flush_valid && younger(bus.int_robid, bus.flush_robid);
    mem_killed   = bus.mem_valid && bus.flush_valid && younger(bus.mem_robid, bus.flush_robid);
    int_ok       = bus.int_valid && !int_killed;
    mem_ok       = bus.mem_valid && !mem_killed;
    head_live    = (count != '0) && ent_valid[rd_ptr] && !kill_vec[rd_ptr];
    silent_pop   = (count != '0) && !head_live;
    fifo_drained = (count == '0) || ((count == CW'(1)) && silent_pop);
    bypass       = !int_ok && !head_live && fifo_drained && mem_ok;
    pop          = silent_pop || (!int_ok && head_live);
    push_req     = mem_ok && !bypass;
    overflow     = push_req && (count == FULL_CNT) && !pop;
    push         = push_req && !overflow;
    count_next   = count + CW'(push) - CW'(pop);

    sel_any   = 1'b0;
    sel_need  = 1'b0;
    sel_prd   = '0;
    sel_data  = '0;
    sel_robid = '0;
    sel_mmio  = 1'b0;
    if (int_ok) begin
      sel_any   = 1'b1;
      sel_need  = bus.int_need_to_wb;
      sel_prd   = bus.int_prd;
      sel_data  = bus.int_result;
      sel_robid = bus.int_robid;
    end else if (head_live) begin
      sel_any   = 1'b1;
      sel_need  = ent_need[rd_ptr];
      sel_prd   = ent_prd[rd_ptr];
      sel_data  = ent_data[rd_ptr];
      sel_robid = ent_robid[rd_ptr];
      sel_mmio  = ent_mmio[rd_ptr];
    end else if (bypass) begin
      sel_any   = 1'b1;
      sel_need  = bus.mem_need_to_wb;
      sel_prd   = bus.mem_prd;
      sel_data  = bus.mem_result;
      sel_robid = bus.mem_robid;
      sel_mmio  = bus.mem_mmio;
    end
  end

  // Memory-result FIFO: kill clears valid bits, pop frees the head, push appends
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_need[i]  <= 1'b0;
        ent_prd[i]   <= '0;
        ent_data[i]  <= '0;
        ent_robid[i] <= '0;
        ent_mmio[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (kill_vec[i]) ent_valid[i] <= 1'b0;
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end
      if (push) begin
        ent_valid[wr_ptr] <= 1'b1;
        ent_need[wr_ptr]  <= bus.mem_need_to_wb;
        ent_prd[wr_ptr]   <= bus.mem_prd;
        ent_data[wr_ptr]  <= bus.mem_result;
        ent_robid[wr_ptr] <= bus.mem_robid;
        ent_mmio[wr_ptr]  <= bus.mem_mmio;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      count <= count_next;
    end
  end

  // Registered output stage plus stall request and sticky overflow flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.cmt_valid <= 1'b0;
      bus.rf_we     <= 1'b0;
      bus.rf_waddr  <= '0;
      bus.rf_wdata  <= '0;
      bus.cmt_robid <= '0;
      bus.cmt_mmio  <= 1'b0;
      bus.mem_stall <= 1'b0;
      bus.ovf_err   <= 1'b0;
    end else begin
      bus.cmt_valid <= sel_any;
      bus.rf_we     <= sel_any && sel_need;
      bus.rf_waddr  <= sel_prd;
      bus.rf_wdata  <= sel_data;
      bus.cmt_robid <= sel_robid;
      bus.cmt_mmio  <= sel_mmio;
      bus.mem_stall <= (count_next >= STALL_CNT);
      bus.ovf_err   <= bus.ovf_err || overflow;
    end
  end

`ifdef WB_ARB_PERF_EN
  logic [31:0] kill_num;
  logic [32:0] kill_sum;

  // Number of FIFO entries and incoming candidates killed this cycle
  always_comb begin
    kill_num = 32'($countones(kill_vec)) + 32'(int_killed) + 32'(mem_killed);
    kill_sum = {1'b0, bus.perf_kill_cnt} + {1'b0, kill_num};
  end

  // Conflict counter wraps; kill counter saturates at all-ones
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.perf_conflict_cnt <= '0;
      bus.perf_kill_cnt     <= '0;
    end else begin
      if (bus.int_valid && bus.mem_valid)
        bus.perf_conflict_cnt <= bus.perf_conflict_cnt + 32'd1;
      bus.perf_kill_cnt <= kill_sum[32] ? '1 : kill_sum[31:0];
    end
  end
`else
  assign bus.perf_conflict_cnt = '0;
  assign bus.perf_kill_cnt     = '0;
`endif

endmodule
